multicycle_arm_core: RTL

- Parametrised multicycle successor to the single-cycle CPU top.
- One unified memory port with a req/ready handshake, so slow memory can stall the core.
- FSM controller drives a single ALU plus IR/data/ALU-out registers; executes a reduced ARM subset (ADD/SUB/AND/ORR, LDR/STR, B) with NZ flags and EQ/NE conditions.
- Sits between the register file and an external memory/bus model.

---
 rtl/multicycle_arm_core.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_arm_core.sv
// Purpose : multicycle reduced-ARM core (ADD/SUB/AND/ORR, LDR/STR, B; NZ flags, AL/EQ/NE) on one shared memory port.
// Latency : zero-wait CPI = ALU 4, LDR 5, STR 4, B 3, skipped/illegal 2; each memory wait cycle adds 1.
// Backpressure: mem_req/mem_we/mem_addr/mem_wdata are held until mem_ready=1; the core stalls meanwhile.
// Ports   : clk/rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready = unified memory port;
//           retire/illegal = registered one-cycle pulses; pc_dbg = current PC.
module multicycle_arm_core #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              illegal,
    output logic [31:0]       pc_dbg
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, ir, ir_n, data, data_n, aluout, aluout_n;
    logic        nf, nf_n, zf, zf_n;
    logic [31:0] rf [0:14];
    logic        retire_n, illegal_n, req_n, we_n;
    logic [31:0] addr_n, wdata_n;

    // Instruction fields
    logic [3:0]  cond, cmd, rn, rd, rm;
    logic [1:0]  op;
    logic        ibit, sbit;
    assign cond = ir[31:28];
    assign op   = ir[27:26];
    assign ibit = ir[25];
    assign cmd  = ir[24:21];
    assign sbit = ir[20];
    assign rn   = ir[19:16];
    assign rd   = ir[15:12];
    assign rm   = ir[3:0];

    // pc already points past the instruction once it is fetched, so R15 reads pc+4
    logic [31:0] r15_val, rn_val, rm_val, rd_val, src2, alu_res, br_target;
    assign r15_val = pc + 32'd4;
    assign rn_val  = (rn == 4'hF) ? r15_val : rf[rn];
    assign rm_val  = (rm == 4'hF) ? r15_val : rf[rm];
    assign rd_val  = (rd == 4'hF) ? r15_val : rf[rd];
    assign src2    = ibit ? {24'd0, ir[7:0]} : rm_val;
    assign br_target = r15_val + {{6{ir[23]}}, ir[23:0], 2'b00};

    logic cond_ok, cmd_ok;
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b1110: cond_ok = 1'b1;
            4'b0000: cond_ok = zf;
            4'b0001: cond_ok = ~zf;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        cmd_ok  = 1'b1;
        case (cmd)
            4'b0100: alu_res = rn_val + src2;
            4'b0010: alu_res = rn_val - src2;
            4'b0000: alu_res = rn_val & src2;
            4'b1100: alu_res = rn_val | src2;
            default: cmd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            data      <= 32'd0;
            aluout    <= 32'd0;
            nf        <= 1'b0;
            zf        <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 15; i++) rf[i] <= 32'd0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            data      <= data_n;
            aluout    <= aluout_n;
            nf        <= nf_n;
            zf        <= zf_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n[ADDR_W-1:0];
            mem_wdata <= wdata_n;
            retire    <= retire_n;
            illegal   <= illegal_n;
            // Rd=15 writes are dropped
            if (state == S_ALU_WB && rd != 4'hF) rf[rd] <= aluout;
            if (state == S_MEM_WB && rd != 4'hF) rf[rd] <= data;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        data_n    = data;
        aluout_n  = aluout;
        nf_n      = nf;
        zf_n      = zf;
        retire_n  = 1'b0;
        illegal_n = 1'b0;
        case (state)
            S_FETCH: if (mem_req && mem_ready) begin
                ir_n    = mem_rdata;
                pc_n    = pc + 32'd4;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                if (!cond_ok) begin
                    retire_n = 1'b1;
                    state_n  = S_FETCH;
                end else if (op == 2'b11 || (op == 2'b00 && !cmd_ok)) begin
                    illegal_n = 1'b1;
                    retire_n  = 1'b1;
                    state_n   = S_FETCH;
                end else if (op == 2'b00) begin
                    state_n = S_EXEC;
                end else if (op == 2'b01) begin
                    state_n = S_MEM_ADR;
                end else begin
                    state_n = S_BRANCH;
                end
            end
            S_EXEC: begin
                aluout_n = alu_res;
                if (sbit) begin
                    nf_n = alu_res[31];
                    zf_n = (alu_res == 32'd0);
                end
                state_n = S_ALU_WB;
            end
            S_ALU_WB: begin
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEM_ADR: begin
                aluout_n = rn_val + {20'd0, ir[11:0]};
                state_n  = sbit ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: if (mem_req && mem_ready) begin
                data_n  = mem_rdata;
                state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEM_WR: if (mem_req && mem_ready) begin
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            S_BRANCH: begin
                pc_n     = br_target;
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Memory outputs are registered from the next state, so a request is already
    // up in the first cycle of FETCH/MEM_RD/MEM_WR and stays put while stalled.
    always_comb begin
        req_n   = (state_n == S_FETCH) || (state_n == S_MEM_RD) || (state_n == S_MEM_WR);
        we_n    = (state_n == S_MEM_WR);
        addr_n  = 32'd0;
        if (state_n == S_FETCH)                           addr_n = {pc_n[31:2], 2'b00};
        else if (state_n == S_MEM_RD || state_n == S_MEM_WR) addr_n = {aluout_n[31:2], 2'b00};
        wdata_n = we_n ? rd_val : 32'd0;
    end

    assign pc_dbg = pc;

endmodule
